uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at mid-bit and emits the byte with a one-clock flag pulse.
// Optional stop-bit error reporting (frame_err port, WAIT_IDLE state) when UART_RX_FRAME_ERR_EN is defined.
module uart_rx #(
    parameter int unsigned MAX_CNT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       flag
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(MAX_CNT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3
`ifdef UART_RX_FRAME_ERR_EN
        ,
        WAIT_IDLE = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             flag_q, flag_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic             sample;
`ifdef UART_RX_FRAME_ERR_EN
    logic             ferr_q, ferr_d;
`endif

    assign data = data_q;
    assign flag = flag_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = ferr_q;
`endif

    assign sample = (cnt_q == CNT_SAMPLE);

    // Next-state, datapath and output pulse computation
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        flag_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d  = 1'b0;
`endif
        // Counter is held at zero in IDLE so a new frame always starts from a clean phase
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                bit_d = 3'd0;
                if (hist_q && !sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample) begin
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
`ifdef UART_RX_FRAME_ERR_EN
                    if (sync2_q) begin
                        data_d  = shift_q;
                        flag_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
`else
                    data_d  = shift_q;
                    flag_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_RX_FRAME_ERR_EN
            WAIT_IDLE: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= ferr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: byte sequence, back-to-back frames, glitch rejection,
// stop-bit handling (both UART_RX_FRAME_ERR_EN builds), mid-frame reset and flag latency.
module tb_uart_rx;

    localparam int unsigned MAX_CNT = 100;
    localparam int unsigned HALF    = MAX_CNT / 2;
    localparam int unsigned LAT     = 9 * MAX_CNT + HALF + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       flag;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int         flag_cnt = 0;
    int         ferr_cnt = 0;
    int         dbl_cnt  = 0;
    int         both_cnt = 0;
    logic       flag_prev = 1'b0;
    logic [7:0] flag_data_q[$];
    time        flag_time = 0;
    time        fall_time = 0;
    logic [7:0] exp_data;

    always #10 clk = ~clk;

    uart_rx #(.MAX_CNT(MAX_CNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .flag     (flag)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    // Pulse recorder, sampled on the inactive edge
    always @(negedge clk) begin
        if (flag) begin
            flag_cnt++;
            flag_data_q.push_back(data);
            flag_time = $time;
            if (flag_prev) dbl_cnt++;
            if (frame_err) both_cnt++;
        end
        if (frame_err) ferr_cnt++;
        flag_prev = flag;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (MAX_CNT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_time = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++;
        if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", flag); end
        checks++;
        if (dut.state_q !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dut.state_q); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_data = 8'h00;
    endtask

    task automatic test_sequence;
        int fc;
        int base;
        logic [7:0] got;
        fc   = flag_cnt;
        base = flag_data_q.size();
        for (int b = 0; b < 8; b++) send_frame(8'(b), 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (flag_cnt - fc != 8) begin errors++; $display("FAIL seq_count got %0d want 8", flag_cnt - fc); end
        for (int i = 0; i < 8; i++) begin
            if (base + i < flag_data_q.size()) got = flag_data_q[base + i];
            else got = 8'hxx;
            checks++;
            if (got !== 8'(i)) begin errors++; $display("FAIL seq_data[%0d] got %h want %h", i, got, 8'(i)); end
        end
        exp_data = 8'h07;
    endtask

    task automatic test_back_to_back;
        int fc;
        int base;
        logic [7:0] got;
        fc   = flag_cnt;
        base = flag_data_q.size();
        send_frame(8'h55, 1'b1);
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (flag_cnt - fc != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", flag_cnt - fc); end
        got = (base < flag_data_q.size()) ? flag_data_q[base] : 8'hxx;
        checks++;
        if (got !== 8'h55) begin errors++; $display("FAIL b2b_first got %h want 55", got); end
        got = (base + 1 < flag_data_q.size()) ? flag_data_q[base + 1] : 8'hxx;
        checks++;
        if (got !== 8'hA5) begin errors++; $display("FAIL b2b_second got %h want a5", got); end
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL b2b_hold got %h want a5", data); end
        exp_data = 8'hA5;
    endtask

    task automatic test_latency;
        int lat;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        lat = int'((flag_time - fall_time) / 20);
        checks++;
        if (lat < int'(LAT) - 2 || lat > int'(LAT) + 2) begin
            errors++; $display("FAIL latency got %0d want %0d+/-2", lat, LAT);
        end
        checks++;
        if (data !== 8'h5A) begin errors++; $display("FAIL latency_data got %h want 5a", data); end
        exp_data = 8'h5A;
    endtask

    task automatic test_glitch;
        int fc;
        int ec;
        fc = flag_cnt;
        ec = ferr_cnt;
        rx = 1'b0;
        repeat (HALF - 20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * MAX_CNT) @(negedge clk);
        checks++;
        if (flag_cnt != fc) begin errors++; $display("FAIL glitch_flag got %0d pulses want 0", flag_cnt - fc); end
        checks++;
        if (ferr_cnt != ec) begin errors++; $display("FAIL glitch_ferr got %0d pulses want 0", ferr_cnt - ec); end
        checks++;
        if (dut.state_q !== 3'd0) begin errors++; $display("FAIL glitch_state got %0d want 0", dut.state_q); end
        checks++;
        if (data !== exp_data) begin errors++; $display("FAIL glitch_data got %h want %h", data, exp_data); end
    endtask

    task automatic test_stop_bit;
        int fc;
        int ec;
        fc = flag_cnt;
        ec = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (MAX_CNT) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
        checks++;
        if (ferr_cnt - ec != 1) begin errors++; $display("FAIL stop_ferr got %0d pulses want 1", ferr_cnt - ec); end
        checks++;
        if (flag_cnt != fc) begin errors++; $display("FAIL stop_flag got %0d pulses want 0", flag_cnt - fc); end
        checks++;
        if (data !== exp_data) begin errors++; $display("FAIL stop_data got %h want %h", data, exp_data); end
`else
        checks++;
        if (flag_cnt - fc != 1) begin errors++; $display("FAIL stop_flag got %0d pulses want 1", flag_cnt - fc); end
        checks++;
        if (data !== 8'h3C) begin errors++; $display("FAIL stop_data got %h want 3c", data); end
        checks++;
        if (ferr_cnt != ec) begin errors++; $display("FAIL stop_ferr got %0d pulses want 0", ferr_cnt - ec); end
        exp_data = 8'h3C;
`endif
        send_frame(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (data !== 8'hC3) begin errors++; $display("FAIL stop_recover got %h want c3", data); end
        exp_data = 8'hC3;
    endtask

    task automatic test_reset_midframe;
        int fc;
        fc = flag_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data); end
        rst = 1'b0;
        repeat (MAX_CNT - HALF - 3) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (flag_cnt != fc) begin errors++; $display("FAIL midrst_flag got %0d pulses want 0", flag_cnt - fc); end
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (flag_cnt - fc != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", flag_cnt - fc); end
        checks++;
        if (data !== 8'h81) begin errors++; $display("FAIL midrst_new got %h want 81", data); end
        exp_data = 8'h81;
    endtask

    task automatic test_flag_rules;
        checks++;
        if (dbl_cnt != 0) begin errors++; $display("FAIL flag_double got %0d want 0", dbl_cnt); end
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL flag_with_ferr got %0d want 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequence();
        test_back_to_back();
        test_latency();
        test_glitch();
        test_stop_bit();
        test_reset_midframe();
        test_flag_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
